// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the four-CLB adder fabric configuration path.
// Holds the loader state encoding, the error-code values reported on
// err_code, and the default framing constants. The bitfile generator and
// the testbench use the same constants.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CFG,
    GET_CHK,
    COMMIT,
    HOLD
  } cfg_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SYNC    = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_CHK_KEY   = 8'h5A;

  // Checksum byte a well-formed frame carries for a given config byte.
  function automatic logic [7:0] chk_byte(input logic [7:0] cfg, input logic [7:0] key);
    return cfg ^ key;
  endfunction

endpackage

// File: rtl/cfg_cycle_counter.sv
// 8-bit load/clear/decrement counter with a terminal-count flag.
// The loader uses it as the mid-frame idle timer and as the hold timer;
// the two uses never overlap, so one counter serves both.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   clear         force count to zero (highest priority)
//   load          load load_value
//   dec           decrement by one, sticking at zero
//   load_value    value taken on load
//   tc            high while count is zero
module cfg_cycle_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_value,
  output logic       tc
);

  logic [7:0] count;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign tc = (count == 8'd0);

endmodule

// File: rtl/bitfile_loader.sv
// Configuration controller for the four-CLB adder fabric.
// Accepts a three-byte frame (sync, config, checksum) over valid/ready,
// commits the config byte to the routing channel on a good frame, then
// holds the fabric in reset for HOLD_CYCLES cycles after the commit cycle
// so the registered CLB slices flush stale results.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   s_data/s_valid/s_ready  configuration byte stream
//   bitfile        active configuration to the routing channel (registered)
//   fabric_hold    ORed into the CLB reset during commit and hold
//   busy           frame in progress, commit or hold
//   cfg_done       one-cycle pulse when a commit and its hold complete
//   cfg_err        one-cycle pulse when a frame is rejected
//   err_code       sticky cause of the last error
//   cfg_count      successful commits, saturating at 255
module bitfile_loader
  import fpga_cfg_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter logic [7:0]  CHK_KEY     = DEF_CHK_KEY,
  parameter int unsigned HOLD_CYCLES = 2,   // 1..255
  parameter int unsigned TIMEOUT     = 16   // 2..255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] bitfile,
  output logic       fabric_hold,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [1:0] err_code,
  output logic [7:0] cfg_count
);

  // The counter runs down to zero, so it is loaded one short of the
  // number of cycles wanted: the terminal cycle itself is the last one.
  localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT - 1);

  cfg_state_t state, state_next;
  logic [7:0] shadow;

  logic       xfer;
  logic       cnt_clear, cnt_load, cnt_dec, cnt_tc;
  logic [7:0] cnt_load_value;
  logic       shadow_load, bitfile_load, hold_done, err_set;
  logic [1:0] err_kind;

  // Handshake outputs come from the state register only, so there is no
  // combinational path from s_valid/s_data to s_ready or fabric_hold.
  assign s_ready     = (state == IDLE) || (state == GET_CFG) || (state == GET_CHK);
  assign fabric_hold = (state == COMMIT) || (state == HOLD);
  assign busy        = (state != IDLE);
  assign xfer        = s_valid && s_ready;

  cfg_cycle_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (cnt_load_value),
    .tc         (cnt_tc)
  );

  // NOTE: every signal driven here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    cnt_clear      = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = TIMEOUT_LOAD;
    shadow_load    = 1'b0;
    bitfile_load   = 1'b0;
    hold_done      = 1'b0;
    err_set        = 1'b0;
    err_kind       = ERR_NONE;

    case (state)
      IDLE: begin
        if (xfer) begin
          if (s_data == SYNC_BYTE) begin
            state_next = GET_CFG;
            cnt_load   = 1'b1;
          end else begin
            err_set  = 1'b1;
            err_kind = ERR_SYNC;
          end
        end
      end

      // Any byte here is config data, including one equal to SYNC_BYTE.
      GET_CFG: begin
        if (xfer) begin
          state_next  = GET_CHK;
          shadow_load = 1'b1;
          cnt_load    = 1'b1;
        end else if (cnt_tc) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
          err_set    = 1'b1;
          err_kind   = ERR_TIMEOUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      GET_CHK: begin
        if (xfer) begin
          if (s_data == chk_byte(shadow, CHK_KEY)) begin
            state_next = COMMIT;
          end else begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
            err_set    = 1'b1;
            err_kind   = ERR_CHK;
          end
        end else if (cnt_tc) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
          err_set    = 1'b1;
          err_kind   = ERR_TIMEOUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      // Single cycle: bitfile takes the whole shadow byte at the exit edge.
      COMMIT: begin
        state_next     = HOLD;
        bitfile_load   = 1'b1;
        cnt_load       = 1'b1;
        cnt_load_value = HOLD_LOAD;
      end

      HOLD: begin
        if (cnt_tc) begin
          state_next = IDLE;
          hold_done  = 1'b1;
          cnt_clear  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      bitfile   <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_code  <= ERR_NONE;
      cfg_count <= '0;
    end else begin
      state    <= state_next;
      cfg_done <= hold_done;
      cfg_err  <= err_set;

      // A rejected frame discards whatever config byte it carried.
      if (shadow_load) begin
        shadow <= s_data;
      end else if (err_set) begin
        shadow <= '0;
      end

      if (bitfile_load) begin
        bitfile <= shadow;
      end

      if (err_set) begin
        err_code <= err_kind;
      end else if (hold_done) begin
        err_code <= ERR_NONE;
      end

      if (hold_done && (cfg_count != 8'hFF)) begin
        cfg_count <= cfg_count + 8'd1;
      end
    end
  end

endmodule
